// File: rtl/seg_display_scanner_if.sv
// seg_display_scanner_if: register-side inputs and display-pin outputs of the scanner
interface seg_display_scanner_if #(
  parameter int NUM_DIGITS  = 8,
  parameter int BRIGHT_BITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   point;
  logic [NUM_DIGITS-1:0]   enable;
  logic [BRIGHT_BITS-1:0]  brightness;
  logic                    lz_suppress;
  logic [7:0]              segment;
  logic [NUM_DIGITS-1:0]   digit;
  logic                    frame_done;
  modport master (
    output value, point, enable, brightness, lz_suppress,
    input  segment, digit, frame_done
  );
  modport slave (
    input  value, point, enable, brightness, lz_suppress,
    output segment, digit, frame_done
  );
endinterface

// File: rtl/seg_display_scanner.sv
// seg_display_scanner: multiplexed common-anode 7-segment driver with PWM, LZ blanking and frame snapshots
module seg_display_scanner #(
  parameter int NUM_DIGITS  = 8,
  parameter int DIV_BITS    = 16,
  parameter int BRIGHT_BITS = 4
) (
  input logic clock,
  input logic reset,
  seg_display_scanner_if.slave bus
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic [DIV_BITS-1:0]     slot_cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] value_sh;
  logic [NUM_DIGITS-1:0]   point_sh;
  logic [NUM_DIGITS-1:0]   enable_sh;
  logic [NUM_DIGITS-1:0]   supp;
  logic                    lead;
  logic                    snap;
  logic                    on;
  logic [3:0]              nib;
  assign snap = slot_cnt == '0 && idx == '0;
  assign nib  = value_sh[4*idx +: 4];
  assign on   = enable_sh[idx] && !supp[idx] && slot_cnt[DIV_BITS-1 -: BRIGHT_BITS] <= bus.brightness;
  // slot timer and digit index; idx steps when the slot counter wraps
  always_ff @(posedge clock) begin
    if (!reset) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      if (&slot_cnt) idx <= idx == IW'(NUM_DIGITS-1) ? '0 : idx + 1'b1;
    end
  end
  // capture inputs only at the frame boundary so a frame never mixes old and new data
  always_ff @(posedge clock) begin
    if (!reset) begin
      value_sh  <= '0;
      point_sh  <= '0;
      enable_sh <= '0;
    end else if (snap) begin
      value_sh  <= bus.value;
      point_sh  <= bus.point;
      enable_sh <= bus.enable;
    end
  end
  // leading-zero run from the top digit down; digit 0 is never part of it
  always_comb begin
    supp = '0;
    lead = bus.lz_suppress;
    for (int k = NUM_DIGITS-1; k > 0; k--) begin
      lead    = lead && value_sh[4*k +: 4] == 4'h0 && !point_sh[k];
      supp[k] = lead;
    end
  end
  // registered pin drive, one cycle behind the scan state
  always_ff @(posedge clock) begin
    if (!reset) begin
      bus.segment    <= 8'hFF;
      bus.digit      <= '1;
      bus.frame_done <= 1'b0;
    end else begin
      bus.segment    <= on ? {~point_sh[idx], HEX[nib]} : 8'hFF;
      bus.digit      <= on ? ~(NUM_DIGITS'(1) << idx) : '1;
      bus.frame_done <= snap;
    end
  end
endmodule

// File: tb/tb_seg_display_scanner.sv
// tb_seg_display_scanner: scoreboard bench for the display scanner (4 digits, 16-clock slots)
module tb_seg_display_scanner;
  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] dig;
    logic       fd;
  } exp_t;
  localparam logic [6:0] HEX_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic clock = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  int m_slot = 0;
  int m_idx = 0;
  logic [15:0] m_val = '0;
  logic [3:0] m_pt = '0;
  logic [3:0] m_en = '0;
  seg_display_scanner_if #(.NUM_DIGITS(4), .BRIGHT_BITS(2)) bus ();
  seg_display_scanner #(.NUM_DIGITS(4), .DIV_BITS(4), .BRIGHT_BITS(2)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clock = ~clock;
  // reference: output for this cycle from frame position, shadows and live inputs
  function automatic exp_t model_out();
    exp_t e;
    int top;
    logic lit;
    top = 0;
    for (int k = 0; k < 4; k++) if (m_val[4*k +: 4] != 4'h0 || m_pt[k]) top = k;
    lit = m_en[m_idx] && !(bus.lz_suppress && m_idx > top) && (m_slot / 4 <= int'(bus.brightness));
    e.fd  = m_slot == 0 && m_idx == 0;
    e.seg = lit ? {~m_pt[m_idx], HEX_TAB[m_val[4*m_idx +: 4]]} : 8'hFF;
    e.dig = lit ? ~(4'b0001 << m_idx) : 4'hF;
    return e;
  endfunction
  // push the expected output of every edge, advance the reference scan
  always @(posedge clock) begin
    if (!reset) begin
      sb.push_back({8'hFF, 4'hF, 1'b0});
      m_slot <= 0;
      m_idx  <= 0;
      m_val  <= '0;
      m_pt   <= '0;
      m_en   <= '0;
    end else begin
      sb.push_back(model_out());
      if (m_slot == 0 && m_idx == 0) begin
        m_val <= bus.value;
        m_pt  <= bus.point;
        m_en  <= bus.enable;
      end
      m_slot <= (m_slot + 1) % 16;
      if (m_slot == 15) m_idx <= (m_idx + 1) % 4;
    end
  end
  function automatic exp_t got();
    return {bus.segment, bus.digit, bus.frame_done};
  endfunction
  task automatic pop_exp(output exp_t e, output bit ok);
    ok = sb.size() > 0;
    e = '0;
    if (ok) e = sb.pop_front();
  endtask
  task automatic test_reset();
    exp_t e;
    bit ok;
    int n0 = 0, n1 = 0, n2 = 0, n3 = 0, fdn = 0;
    reset = 1'b0;
    bus.value = 16'h1234;
    bus.enable = 4'hF;
    bus.point = 4'h0;
    bus.brightness = 2'd3;
    bus.lz_suppress = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      pop_exp(e, ok);
      checks++;
      if (!ok || got() !== e) begin
        errors++;
        $display("FAIL reset_sb i=%0d: got %h expected %h (queued=%0b)", i, got(), e, ok);
      end
      checks++;
      if (bus.segment !== 8'hFF || bus.digit !== 4'hF || bus.frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_value i=%0d: seg=%h dig=%h fd=%b, want FF F 0", i, bus.segment, bus.digit, bus.frame_done);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 128; i++) begin
      @(negedge clock);
      pop_exp(e, ok);
      checks++;
      if (!ok || got() !== e) begin
        errors++;
        $display("FAIL scan_sb i=%0d: got %h expected %h (queued=%0b)", i, got(), e, ok);
      end
      if (i == 0) begin
        checks++;
        if (bus.digit !== 4'hF || bus.frame_done !== 1'b1) begin
          errors++;
          $display("FAIL first_out: dig=%h fd=%b, want F 1", bus.digit, bus.frame_done);
        end
      end
      n0 += int'(bus.digit == 4'hE && bus.segment == 8'h99);
      n1 += int'(bus.digit == 4'hD && bus.segment == 8'hB0);
      n2 += int'(bus.digit == 4'hB && bus.segment == 8'hA4);
      n3 += int'(bus.digit == 4'h7 && bus.segment == 8'hF9);
      fdn += int'(bus.frame_done);
    end
    checks++;
    if (n0 != 31 || n1 != 32 || n2 != 32 || n3 != 32) begin
      errors++;
      $display("FAIL scan_counts: d0=%0d d1=%0d d2=%0d d3=%0d, want 31 32 32 32", n0, n1, n2, n3);
    end
    checks++;
    if (fdn != 2) begin
      errors++;
      $display("FAIL frame_done_count: got %0d want 2", fdn);
    end
  endtask
  task automatic test_tear_free();
    exp_t e;
    bit ok;
    int early = 0, late = 0;
    for (int i = 0; i < 128; i++) begin
      @(negedge clock);
      pop_exp(e, ok);
      checks++;
      if (!ok || got() !== e) begin
        errors++;
        $display("FAIL tear_sb i=%0d: got %h expected %h (queued=%0b)", i, got(), e, ok);
      end
      if (bus.segment == 8'h88) begin
        if (i < 64) early++;
        else late++;
      end
      if (i == 20) bus.value = 16'hAAAA;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL tear_same_frame: %0d cycles of 88, want 0", early);
    end
    checks++;
    if (late != 63) begin
      errors++;
      $display("FAIL tear_next_frame: %0d cycles of 88, want 63", late);
    end
  endtask
  task automatic test_brightness();
    exp_t e;
    bit ok;
    int low [4];
    for (int b = 0; b < 2; b++) begin
      bus.brightness = 2'(b);
      low = '{0, 0, 0, 0};
      for (int i = 0; i < 64; i++) begin
        @(negedge clock);
        pop_exp(e, ok);
        checks++;
        if (!ok || got() !== e) begin
          errors++;
          $display("FAIL bright_sb b=%0d i=%0d: got %h expected %h (queued=%0b)", b, i, got(), e, ok);
        end
        for (int k = 0; k < 4; k++) low[k] += int'(bus.digit == ~(4'b0001 << k));
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (low[k] != 4 * (b + 1)) begin
          errors++;
          $display("FAIL bright_duty b=%0d digit %0d: on %0d cycles, want %0d", b, k, low[k], 4 * (b + 1));
        end
      end
    end
    bus.brightness = 2'd3;
  endtask
  task automatic test_leading_zeros();
    exp_t e;
    bit ok;
    int low [4];
    int hit [4];
    logic [15:0] vals [3] = '{16'h0050, 16'h0000, 16'h0000};
    logic [3:0] pts [3] = '{4'b0000, 4'b0000, 4'b0100};
    int want [3][4] = '{'{16, 16, 0, 0}, '{16, 0, 0, 0}, '{16, 16, 16, 0}};
    logic [7:0] segs [3][4] = '{'{8'hC0, 8'h92, 8'hFF, 8'hFF}, '{8'hC0, 8'hFF, 8'hFF, 8'hFF}, '{8'hC0, 8'hC0, 8'h40, 8'hFF}};
    bus.lz_suppress = 1'b1;
    for (int p = 0; p < 3; p++) begin
      bus.value = vals[p];
      bus.point = pts[p];
      low = '{0, 0, 0, 0};
      hit = '{0, 0, 0, 0};
      for (int i = 0; i < 128; i++) begin
        @(negedge clock);
        pop_exp(e, ok);
        checks++;
        if (!ok || got() !== e) begin
          errors++;
          $display("FAIL lz_sb p=%0d i=%0d: got %h expected %h (queued=%0b)", p, i, got(), e, ok);
        end
        if (i >= 64)
          for (int k = 0; k < 4; k++) begin
            low[k] += int'(bus.digit == ~(4'b0001 << k));
            hit[k] += int'(bus.digit == ~(4'b0001 << k) && bus.segment == segs[p][k]);
          end
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (low[k] != want[p][k] || hit[k] != want[p][k]) begin
          errors++;
          $display("FAIL lz p=%0d digit %0d: on %0d, pattern %0d, want %0d", p, k, low[k], hit[k], want[p][k]);
        end
      end
    end
    bus.lz_suppress = 1'b0;
  endtask
  task automatic test_enable_point();
    exp_t e;
    bit ok;
    int low [4] = '{0, 0, 0, 0};
    int hit [4] = '{0, 0, 0, 0};
    int want [4] = '{16, 0, 16, 0};
    logic [7:0] segs [4] = '{8'h00, 8'hFF, 8'h80, 8'hFF};
    bus.enable = 4'b0101;
    bus.point = 4'b0001;
    bus.value = 16'h8888;
    for (int i = 0; i < 128; i++) begin
      @(negedge clock);
      pop_exp(e, ok);
      checks++;
      if (!ok || got() !== e) begin
        errors++;
        $display("FAIL enpt_sb i=%0d: got %h expected %h (queued=%0b)", i, got(), e, ok);
      end
      if (i >= 64)
        for (int k = 0; k < 4; k++) begin
          low[k] += int'(bus.digit == ~(4'b0001 << k));
          hit[k] += int'(bus.digit == ~(4'b0001 << k) && bus.segment == segs[k]);
        end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (low[k] != want[k] || hit[k] != want[k]) begin
        errors++;
        $display("FAIL enpt digit %0d: on %0d, pattern %0d, want %0d", k, low[k], hit[k], want[k]);
      end
    end
  endtask
  task automatic test_mid_frame_reset();
    exp_t e;
    bit ok;
    int n0 = 0, fdn = 0;
    bus.enable = 4'hF;
    bus.point = 4'h0;
    bus.value = 16'h1234;
    for (int i = 0; i < 106; i++) begin
      @(negedge clock);
      pop_exp(e, ok);
      checks++;
      if (!ok || got() !== e) begin
        errors++;
        $display("FAIL midrst_sb i=%0d: got %h expected %h (queued=%0b)", i, got(), e, ok);
      end
      if (i == 41) begin
        checks++;
        if (bus.segment !== 8'hFF || bus.digit !== 4'hF || bus.frame_done !== 1'b0) begin
          errors++;
          $display("FAIL midrst_blank: seg=%h dig=%h fd=%b, want FF F 0", bus.segment, bus.digit, bus.frame_done);
        end
      end
      if (i == 42) begin
        checks++;
        if (bus.digit !== 4'hF || bus.frame_done !== 1'b1) begin
          errors++;
          $display("FAIL midrst_restart: dig=%h fd=%b, want F 1", bus.digit, bus.frame_done);
        end
      end
      if (i >= 43 && i < 58) n0 += int'(bus.digit == 4'hE && bus.segment == 8'h99);
      fdn += int'(bus.frame_done);
      if (i == 40) reset = 1'b0;
      if (i == 41) reset = 1'b1;
    end
    checks++;
    if (n0 != 15) begin
      errors++;
      $display("FAIL midrst_digit0: %0d cycles of E/99, want 15", n0);
    end
    checks++;
    if (fdn != 2) begin
      errors++;
      $display("FAIL midrst_frames: %0d frame_done pulses, want 2", fdn);
    end
  endtask
  initial begin
    test_reset();
    test_tear_free();
    test_brightness();
    test_leading_zeros();
    test_enable_point();
    test_mid_frame_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_display_scanner.md
# seg_display_scanner

Parametrised multiplexed seven-segment display driver. It is the successor to the fixed 8-digit display interface, generalised in digit count and refresh rate. It adds per-digit PWM brightness, leading-zero suppression and tear-free frame-boundary snapshotting of its inputs. It sits between the memory-mapped display registers and the board's common-anode display pins.

## Interface
Parameters:
- NUM_DIGITS, 8, number of digits scanned (1..16)
- DIV_BITS, 16, width of the slot counter; each digit slot lasts 2^DIV_BITS clocks
- BRIGHT_BITS, 4, width of the brightness input; must satisfy BRIGHT_BITS <= DIV_BITS

Ports:
- clock  in  1  system clock; all logic is on the rising edge
- reset  in  1  synchronous, active-low reset
- value  in  4*NUM_DIGITS  hex nibbles; nibble k drives digit k (digit 0 is the LS nibble)
- point  in  NUM_DIGITS  1 = decimal point lit on digit k
- enable  in  NUM_DIGITS  1 = digit k is displayed; 0 = digit k is blank
- brightness  in  BRIGHT_BITS  duty-cycle code; all-ones = 100 %
- lz_suppress  in  1  1 = blank leading zero digits
- segment  out  8  active-low; [6:0] = g,f,e,d,c,b,a; [7] = dp
- digit  out  NUM_DIGITS  active-low anode enables, one-hot-low or all-high
- frame_done  out  1  one-cycle pulse at each frame boundary

## Operation
- slot_cnt (DIV_BITS) increments every clock and wraps to 0. On a wrap, idx (0..NUM_DIGITS-1) advances. idx wraps from NUM_DIGITS-1 to 0.
- Snapshot: in any cycle with slot_cnt==0 and idx==0, value, point and enable are captured into shadow registers. All display logic uses only the shadows. Input changes mid-frame never tear the display.
- Leading-zero suppression, computed from the shadows:
  - When lz_suppress=1, scan from digit NUM_DIGITS-1 downward.
  - Each digit whose nibble is 0 and whose point bit is 0 is treated as disabled.
  - The scan stops at the first digit with a non-zero nibble or a set point bit.
  - Digit 0 is never suppressed.
  - lz_suppress is sampled live, not snapshotted.
- Effective enable for idx = shadow enable[idx] AND NOT suppressed[idx].
- PWM:
  - The anode is on when effective enable is 1 and slot_cnt[DIV_BITS-1 -: BRIGHT_BITS] <= brightness.
  - On-time per slot is therefore (brightness+1)·2^(DIV_BITS-BRIGHT_BITS) clocks.
  - brightness is sampled live.
- Anode on: digit = ~(1<<idx), and segment = {~point_sh[idx], hex pattern of nibble idx}.
- Anode off: digit all ones and segment = 8'hFF.
- Hex patterns for [6:0], active-low:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E

## Timing
- Reset values (reset=0 at an edge):
  - slot_cnt=0, idx=0, all shadows=0 (display blank)
  - segment=8'hFF, digit=all ones, frame_done=0
- After reset is released, the first cycle is a snapshot cycle. Inputs present at that first active edge are loaded.
- segment, digit and frame_done are registered. The output in cycle t+1 reflects idx, slot_cnt, shadows and live inputs in cycle t, a one-cycle latency.
- Consequences of that latency:
  - The first output cycle after reset is blank.
  - The final cycle of each slot's output appears one cycle late.
  - Anode changes are always single-step: no two digits are ever low together.
- frame_done is high for the one output cycle corresponding to the snapshot cycle. It first appears in cycle 1 after reset release, then every NUM_DIGITS·2^DIV_BITS clocks.
- Reset mid-frame: all outputs return to their reset values at the next edge, regardless of idx or slot position.
- An input change in the same cycle as a snapshot is captured. A change one cycle later waits a full frame.

## Test plan
Use NUM_DIGITS=4, DIV_BITS=4, BRIGHT_BITS=2, brightness=3, lz_suppress=0 unless stated otherwise.
- Reset/scan:
  - Stimulus: hold reset=0 for 3 cycles with value=16'h1234, enable=4'hF, point=0.
  - Required response: segment=FF and digit=F during reset.
  - After release: digit=E with segment=99 (nibble 4) for 16 cycles, then D/B0, B/A4, 7/F9, wrapping every 64 cycles. frame_done pulses every 64.
- Tear-free update:
  - Stimulus: change value to 16'hAAAA mid-frame (idx=1).
  - Required response: the remainder of the frame still shows 1234. The next frame shows segment=88 on all digits.
- Brightness:
  - Stimulus: brightness=0.
  - Required response: each digit's anode is low for exactly 4 of its 16 cycles.
  - Stimulus: brightness=1.
  - Required response: each digit's anode is low for 8 of 16 cycles.
- Leading zeros:
  - Stimulus: value=16'h0050, lz_suppress=1, point=0.
  - Required response: digits 3 and 2 are blank; digits 1 (92) and 0 (C0) are shown.
  - Stimulus: value=0, lz_suppress=1.
  - Required response: only digit 0 is shown, as C0.
  - Stimulus: point=4'b0100.
  - Required response: digit 2 is shown as 40.
- Enable/point:
  - Stimulus: enable=4'b0101, point=4'b0001, value=16'h8888.
  - Required response: digits 1 and 3 are never driven; digit 0 shows 00; digit 2 shows 80.
- Mid-frame reset:
  - Stimulus: reset=0 for one cycle at idx=2.
  - Required response: the next output is FF / F. Scanning restarts at digit 0 with a fresh snapshot.
